// File: rtl/bram_port_arbiter_if.sv
// Bundle of requester-side and BRAM-side signals for bram_port_arbiter.
// Handshake (both sides use the same level/pulse scheme):
//   requester: port_req[p] is a level held, together with port_write/addr/wdata[p],
//              until the cycle in which port_valid[p] or port_err[p] pulses; dropping it in
//              that cycle ends the exchange, keeping it high starts a new transaction.
//   BRAM:      mem_req is a level held with mem_write/addr/wdata stable until the cycle in
//              which mem_valid is seen; mem_rdata is taken in that same cycle.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface bram_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS  = 15
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            port_req;
  logic [NUM_PORTS-1:0]            port_write;
  logic [NUM_PORTS*ADDR_BITS-1:0]  port_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata;
  logic [DATA_WIDTH-1:0]           port_rdata;
  logic [NUM_PORTS-1:0]            port_valid;
  logic [NUM_PORTS-1:0]            port_err;
  logic                            mem_req;
  logic                            mem_write;
  logic [ADDR_BITS-1:0]            mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            mem_valid;
  logic [GW-1:0]                   grant_id;
  logic                            busy;

  modport slave (
    input  port_req, port_write, port_addr, port_wdata, mem_rdata, mem_valid,
    output port_rdata, port_valid, port_err, mem_req, mem_write, mem_addr, mem_wdata,
           grant_id, busy
  );

  modport master (
    output port_req, port_write, port_addr, port_wdata, mem_rdata, mem_valid,
    input  port_rdata, port_valid, port_err, mem_req, mem_write, mem_addr, mem_wdata,
           grant_id, busy
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// N-port arbiter sharing one single-port BRAM. One transaction owns the BRAM at a time:
// IDLE picks a winner and latches its command, ISSUE/WAIT hold mem_req until the BRAM
// completes or the watchdog expires, RESP pulses port_valid or port_err to the owner.
module bram_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_BITS      = 15,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  bram_port_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int GW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GW-1:0]  PTR_RST = GW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state;
  logic                   mem_req_q;
  logic                   mem_write_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_wdata_q;
  logic [DATA_WIDTH-1:0]  port_rdata_q;
  logic [NUM_PORTS-1:0]   port_valid_q;
  logic [NUM_PORTS-1:0]   port_err_q;
  logic [GW-1:0]          grant_q;
  logic [GW-1:0]          rr_ptr;
  logic [WDW-1:0]         wdog;

  logic [ADDR_BITS-1:0]   addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_PORTS];
  logic [GW-1:0]          winner;
  logic [GW-1:0]          cand;
  logic                   found;
  logic [NUM_PORTS-1:0]   grant_onehot;

  // Split the flattened per-port buses so the winner can be selected by index.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_arr[p]  = bus.port_addr[p*ADDR_BITS +: ADDR_BITS];
    assign wdata_arr[p] = bus.port_wdata[p*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant_onehot = NUM_PORTS'(1) << grant_q;

  // Winner selection: round-robin scans upward from the port after the last owner,
  // fixed priority takes the lowest requesting index.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    if (ROUND_ROBIN != 0) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand = GW'((int'(rr_ptr) + k) % NUM_PORTS);
        if (!found && bus.port_req[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (bus.port_req[GW'(i)]) begin
          winner = GW'(i);
        end
      end
    end
  end

  // Ownership FSM; every output is registered, so reset clears them asynchronously.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      port_rdata_q <= '0;
      port_valid_q <= '0;
      port_err_q   <= '0;
      grant_q      <= '0;
      rr_ptr       <= PTR_RST;
      wdog         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.port_req) begin
            mem_write_q <= bus.port_write[winner];
            mem_addr_q  <= addr_arr[winner];
            mem_wdata_q <= wdata_arr[winner];
            grant_q     <= winner;
            rr_ptr      <= winner;
            mem_req_q   <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the expiry cycle still counts as a completion.
          if (bus.mem_valid) begin
            if (!mem_write_q) begin
              port_rdata_q <= bus.mem_rdata;
            end
            mem_req_q    <= 1'b0;
            port_valid_q <= grant_onehot;
            state        <= S_RESP;
          end else if ((TIMEOUT_CYCLES > 0) && (wdog == WD_LAST)) begin
            mem_req_q  <= 1'b0;
            port_err_q <= grant_onehot;
            state      <= S_RESP;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESP: begin
          port_valid_q <= '0;
          port_err_q   <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.port_rdata = port_rdata_q;
  assign bus.port_valid = port_valid_q;
  assign bus.port_err   = port_err_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state != S_IDLE);
  assign dbg_state      = state;
endmodule
